s_type_store_unit: RTL and testbench

//  Store-side counterpart of the load datapath: executes SB/SH/SW (funct3 from idata[14:12]).

---
 rtl/s_type_store_unit.sv | 165 ++++++++++++++++
 tb/tb_s_type_store_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/s_type_store_unit.sv
// s_type_store_unit: executes SB/SH/SW. Forms ea = rv1 + imm, places the
// store bytes on their lanes and writes them through a req/ack port as one
// aligned beat, or two when the store crosses a word boundary.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | st_ready=1, waiting for st_valid
// WR0    | first (or only) aligned beat on the write port
// WR1    | second beat of a boundary-crossing store (next word up)
// DONE   | st_done pulse, port quiet
// ERR    | st_err pulse: bad funct3, rejected misalignment, or ack timeout
module s_type_store_unit #(
  parameter int ALLOW_MISALIGNED = 1,
  parameter int ACK_TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] rv1,
  input  logic [31:0] rv2,
  input  logic [31:0] imm,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  output logic        st_done,
  output logic        st_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR0  = 3'd1,
    S_WR1  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // The timer counts waiting cycles of the current beat; the beat is abandoned
  // on the waiting cycle that would make the count reach ACK_TIMEOUT.
  localparam bit          TMO_EN   = (ACK_TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = (ACK_TIMEOUT == 0) ? 16'd0 : 16'(ACK_TIMEOUT - 1);

  state_t      r_state;
  logic        r_mem_req;
  logic [31:0] r_daddr;
  logic [31:0] r_dwdata;
  logic [3:0]  r_dwe;
  logic        r_st_done;
  logic        r_st_err;
  logic [3:0]  r_hi_dwe;
  logic [31:0] r_hi_dwdata;
  logic [15:0] r_timer;

  logic [31:0] w_ea;
  logic [1:0]  w_off;
  logic [3:0]  w_mask;
  logic        w_legal;
  logic        w_misal;
  logic [7:0]  w_m8;
  logic [63:0] w_d64;
  logic        w_tmo_hit;

  assign w_ea  = rv1 + imm;
  assign w_off = w_ea[1:0];

  // Decode access size into a byte mask and flag illegal or misaligned requests.
  always_comb begin
    w_mask  = 4'b0000;
    w_legal = 1'b1;
    w_misal = 1'b0;
    case (funct3)
      3'b000: w_mask = 4'b0001;
      3'b001: begin
        w_mask  = 4'b0011;
        w_misal = w_off[0];
      end
      3'b010: begin
        w_mask  = 4'b1111;
        w_misal = (w_off != 2'b00);
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Two-word window: the upper halves become the second beat when non-empty.
  assign w_m8      = {4'b0000, w_mask} << w_off;
  assign w_d64     = {32'h0, rv2} << {w_off, 3'b000};
  assign w_tmo_hit = TMO_EN && (r_timer == TMO_LAST);

  // Sequencer: all port outputs are registered so a beat holds steady until acked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_daddr     <= 32'h0;
      r_dwdata    <= 32'h0;
      r_dwe       <= 4'b0000;
      r_st_done   <= 1'b0;
      r_st_err    <= 1'b0;
      r_hi_dwe    <= 4'b0000;
      r_hi_dwdata <= 32'h0;
      r_timer     <= 16'd0;
    end else begin
      r_st_done <= 1'b0;
      r_st_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (st_valid) begin
            if (!w_legal || (w_misal && (ALLOW_MISALIGNED == 0))) begin
              r_state  <= S_ERR;
              r_st_err <= 1'b1;
            end else begin
              r_state     <= S_WR0;
              r_mem_req   <= 1'b1;
              r_daddr     <= {w_ea[31:2], 2'b00};
              r_dwe       <= w_m8[3:0];
              r_dwdata    <= w_d64[31:0];
              r_hi_dwe    <= w_m8[7:4];
              r_hi_dwdata <= w_d64[63:32];
              r_timer     <= 16'd0;
            end
          end
        end
        S_WR0, S_WR1: begin
          if (mem_ack) begin
            r_timer <= 16'd0;
            if ((r_state == S_WR0) && (r_hi_dwe != 4'b0000)) begin
              r_state  <= S_WR1;
              r_daddr  <= r_daddr + 32'd4;
              r_dwe    <= r_hi_dwe;
              r_dwdata <= r_hi_dwdata;
            end else begin
              r_state   <= S_DONE;
              r_mem_req <= 1'b0;
              r_dwe     <= 4'b0000;
              r_st_done <= 1'b1;
            end
          end else if (w_tmo_hit) begin
            // A first beat already written stays written; only the error is reported.
            r_state   <= S_ERR;
            r_mem_req <= 1'b0;
            r_dwe     <= 4'b0000;
            r_st_err  <= 1'b1;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_DONE, S_ERR: r_state <= S_IDLE;
        default:       r_state <= S_IDLE;
      endcase
    end
  end

  assign st_ready = (r_state == S_IDLE);
  assign mem_req  = r_mem_req;
  assign daddr    = r_daddr;
  assign dwdata   = r_dwdata;
  assign dwe      = r_dwe;
  assign st_done  = r_st_done;
  assign st_err   = r_st_err;

endmodule

// File: tb/tb_s_type_store_unit.sv
// Bench for s_type_store_unit. Unit A: misaligned allowed, ack timeout 4.
// Unit B: misaligned rejected, no timeout. Expected beats come from a
// byte-at-a-time model: each store byte lands at ea+i, grouped by word.
module tb_s_type_store_unit;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  dwe;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        st_valid = 1'b0;
  logic        sel = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rv1 = 32'h0, rv2 = 32'h0, imm = 32'h0;
  logic        mem_ack = 1'b0;

  logic        a_ready, a_req, a_done, a_err;
  logic [31:0] a_daddr, a_dwdata;
  logic [3:0]  a_dwe;
  logic        b_ready, b_req, b_done, b_err;
  logic [31:0] b_daddr, b_dwdata;
  logic [3:0]  b_dwe;

  logic        o_ready, o_req, o_done, o_err;
  logic [31:0] o_daddr, o_dwdata;
  logic [3:0]  o_dwe;

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t exp_q[$];
  beat_t mdl_q[$];

  always #5 clk = ~clk;

  s_type_store_unit #(.ALLOW_MISALIGNED(1), .ACK_TIMEOUT(4)) u_a (
    .clk(clk), .reset(reset), .st_valid(st_valid & ~sel), .st_ready(a_ready),
    .funct3(funct3), .rv1(rv1), .rv2(rv2), .imm(imm),
    .mem_req(a_req), .mem_ack(mem_ack), .daddr(a_daddr), .dwdata(a_dwdata),
    .dwe(a_dwe), .st_done(a_done), .st_err(a_err));

  s_type_store_unit #(.ALLOW_MISALIGNED(0), .ACK_TIMEOUT(0)) u_b (
    .clk(clk), .reset(reset), .st_valid(st_valid & sel), .st_ready(b_ready),
    .funct3(funct3), .rv1(rv1), .rv2(rv2), .imm(imm),
    .mem_req(b_req), .mem_ack(mem_ack), .daddr(b_daddr), .dwdata(b_dwdata),
    .dwe(b_dwe), .st_done(b_done), .st_err(b_err));

  assign o_ready  = sel ? b_ready  : a_ready;
  assign o_req    = sel ? b_req    : a_req;
  assign o_done   = sel ? b_done   : a_done;
  assign o_err    = sel ? b_err    : a_err;
  assign o_daddr  = sel ? b_daddr  : a_daddr;
  assign o_dwdata = sel ? b_dwdata : a_dwdata;
  assign o_dwe    = sel ? b_dwe    : a_dwe;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte-level model: byte i of rv2 goes to address ea+i.
  task automatic model_beats(input logic [31:0] ea, input int size, input logic [31:0] data);
    beat_t       b;
    logic [31:0] a;
    int          lane;
    mdl_q.delete();
    for (int i = 0; i < size; i++) begin
      a    = ea + 32'(i);
      lane = int'(a[1:0]);
      if (mdl_q.size() == 0 || mdl_q[mdl_q.size()-1].addr != (a & 32'hFFFF_FFFC)) begin
        b.addr = a & 32'hFFFF_FFFC;
        b.dwe  = 4'b0000;
        b.data = 32'h0;
        mdl_q.push_back(b);
      end
      b = mdl_q[mdl_q.size()-1];
      b.dwe[lane]         = 1'b1;
      b.data[8*lane +: 8] = data[8*i +: 8];
      mdl_q[mdl_q.size()-1] = b;
    end
  endtask

  // Hand-computed beats pin the model.
  task automatic pin(input string nm, input logic [31:0] ea, input int size, input logic [31:0] data,
                     input int idx, input int nbeats, input logic [31:0] ad, input logic [3:0] we,
                     input logic [31:0] wd);
    model_beats(ea, size, data);
    chk({nm, "_nbeats"}, 96'(mdl_q.size()), 96'(nbeats));
    if (mdl_q.size() > idx)
      chk(nm, {mdl_q[idx].addr, 28'h0, mdl_q[idx].dwe, mdl_q[idx].data}, {ad, 28'h0, we, wd});
  endtask

  // Every cycle a beat is presented it must equal the oldest unwritten model beat.
  always @(negedge clk) begin
    if (reset && o_req) begin
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", {o_daddr, 28'h0, o_dwe, o_dwdata}, 96'h0);
      end else begin
        chk("beat", {o_daddr, 28'h0, o_dwe, o_dwdata},
            {exp_q[0].addr, 28'h0, exp_q[0].dwe, exp_q[0].data});
        if (mem_ack) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_store(input string nm, input logic sel_i, input logic [2:0] f3,
                          input logic [31:0] r1, input logic [31:0] im, input logic [31:0] r2,
                          input int delay);
    logic [31:0] ea;
    int  size, tmo, exp_lat, n, wcnt;
    bit  allow, legal, exp_err, seen;
    allow = !sel_i;
    tmo   = sel_i ? 0 : 4;
    ea    = r1 + im;
    legal = 1'b1;
    case (f3)
      3'b000: size = 1;
      3'b001: size = 2;
      3'b010: size = 4;
      default: begin size = 1; legal = 1'b0; end
    endcase
    exp_err = !legal || (!allow && ((int'(ea[1:0]) % size) != 0));
    mdl_q.delete();
    if (!exp_err) model_beats(ea, size, r2);
    if (exp_err)                       exp_lat = 1;
    else if (tmo != 0 && delay >= tmo) begin exp_err = 1'b1; exp_lat = 1 + tmo; end
    else                               exp_lat = 1 + mdl_q.size() * (delay + 1);
    exp_q = mdl_q;
    sel   = sel_i;

    @(posedge clk); #1;
    chk({nm, "_ready_idle"}, 96'(o_ready), 96'(1));
    funct3 = f3; rv1 = r1; imm = im; rv2 = r2; st_valid = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    st_valid = 1'b0;
    n = 1; wcnt = 0; seen = 1'b0;
    chk({nm, "_ready_busy"}, 96'(o_ready), 96'(0));
    while (!seen && n < 60) begin
      if (o_done || o_err) begin
        seen = 1'b1;
        chk({nm, "_outcome"}, {o_done, o_err}, {!exp_err, exp_err});
        chk({nm, "_latency"}, 96'(n), 96'(exp_lat));
      end else begin
        if (o_req) begin
          if (wcnt < delay) begin mem_ack = 1'b0; wcnt++; end
          else begin mem_ack = 1'b1; wcnt = 0; end
        end
        @(posedge clk); #1;
        n++;
      end
    end
    if (!seen) chk({nm, "_no_completion"}, 96'(0), 96'(1));
    if (!exp_err) chk({nm, "_beats_left"}, 96'(exp_q.size()), 96'(0));
    exp_q.delete();
    mem_ack = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_pulse_end"}, {o_done, o_err, o_req}, 3'b000);
  endtask

  initial begin
    bit stray;
    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {a_req, a_dwe, a_daddr, a_dwdata, a_done, a_err, a_ready},
        {1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1});
    reset = 1'b1;

    // Model pins
    pin("pin_sw",      32'h0000_1004, 4, 32'hA1B2_C3D4, 0, 1, 32'h1004, 4'b1111, 32'hA1B2_C3D4);
    pin("pin_sb",      32'h0000_2003, 1, 32'h0000_00F4, 0, 1, 32'h2000, 4'b1000, 32'hF400_0000);
    pin("pin_sh",      32'h0000_2002, 2, 32'h0000_BEEF, 0, 1, 32'h2000, 4'b1100, 32'hBEEF_0000);
    pin("pin_sw_b0",   32'h0000_3001, 4, 32'h1122_3344, 0, 2, 32'h3000, 4'b1110, 32'h2233_4400);
    pin("pin_sw_b1",   32'h0000_3001, 4, 32'h1122_3344, 1, 2, 32'h3004, 4'b0001, 32'h0000_0011);
    pin("pin_sh_b1",   32'h0000_30FF, 2, 32'h0000_BEEF, 1, 2, 32'h3100, 4'b0001, 32'h0000_00BE);
    pin("pin_sh_off1", 32'h0000_4001, 2, 32'h0000_1234, 0, 1, 32'h4000, 4'b0110, 32'h0012_3400);
    pin("pin_wrap",    32'hFFFF_FFFE, 4, 32'hCAFE_F00D, 1, 2, 32'h0000_0000, 4'b0011, 32'h0000_CAFE);

    // Aligned, sub-word and split stores with same-cycle ack
    do_store("sw_aligned", 1'b0, 3'b010, 32'h1000, 32'h4, 32'hA1B2_C3D4, 0);
    do_store("sb_lane3",   1'b0, 3'b000, 32'h2000, 32'h3, 32'h0000_00F4, 0);
    do_store("sh_upper",   1'b0, 3'b001, 32'h2004, 32'hFFFF_FFFE, 32'h0000_BEEF, 0);
    do_store("sw_split",   1'b0, 3'b010, 32'h3000, 32'h1, 32'h1122_3344, 0);
    do_store("sh_split",   1'b0, 3'b001, 32'h3000, 32'hFF, 32'h0000_BEEF, 0);
    do_store("sh_off1",    1'b0, 3'b001, 32'h4000, 32'h1, 32'h0000_1234, 0);
    do_store("sb_off1",    1'b0, 3'b000, 32'h4000, 32'h1, 32'h0000_0077, 0);
    // Delayed acks: beat held stable, then written; split with per-beat delay
    do_store("sw_ack_late", 1'b0, 3'b010, 32'h5000, 32'h0, 32'hDEAD_BEEF, 3);
    do_store("sw_split_d1", 1'b0, 3'b010, 32'h5000, 32'h3, 32'h8899_AABB, 1);
    // Timeout with no ack
    do_store("sb_timeout",  1'b0, 3'b000, 32'h6000, 32'h2, 32'h0000_0055, 100);
    // Illegal funct3 and disallowed misalignment
    do_store("f3_illegal",  1'b0, 3'b011, 32'h7000, 32'h0, 32'h1234_5678, 0);
    do_store("b_misal_sw",  1'b1, 3'b010, 32'h3000, 32'h2, 32'h1122_3344, 0);
    do_store("b_misal_sh",  1'b1, 3'b001, 32'h3000, 32'h1, 32'h0000_1122, 0);
    do_store("b_aligned",   1'b1, 3'b010, 32'h3000, 32'h4, 32'h5566_7788, 2);
    do_store("b_sh_ok",     1'b1, 3'b001, 32'h3000, 32'h2, 32'h0000_ABCD, 0);
    do_store("wrap_split",  1'b0, 3'b010, 32'hFFFF_FFF0, 32'hE, 32'hCAFE_F00D, 0);

    // Async reset during the second beat of a wrapping split store
    sel = 1'b0;
    model_beats(32'hFFFF_FFFE, 4, 32'hCAFE_F00D);
    exp_q = mdl_q;
    @(posedge clk); #1;
    funct3 = 3'b010; rv1 = 32'hFFFF_FFF0; imm = 32'hE; rv2 = 32'hCAFE_F00D;
    st_valid = 1'b1; mem_ack = 1'b1;
    @(posedge clk); #1;
    st_valid = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("rst_wr1_addr", {a_req, a_daddr, a_dwe}, {1'b1, 32'h0, 4'b0011});
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_async", {a_req, a_dwe, a_daddr, a_dwdata, a_ready, a_done, a_err},
        {1'b0, 4'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    reset = 1'b1;
    stray = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      stray = stray | a_done | a_err | a_req | ~a_ready;
    end
    chk("rst_no_done", 96'(stray), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
